// File: rtl/alu_operand_responder.sv
// Memory-side responder for the ALU datapath: stores operand pairs, drives them to the ALU
// one pair at a time, captures each result Z after ALU_LAT cycles and offers a readback port.
module alu_operand_responder #(
   parameter int unsigned AW      = 3,
   parameter int unsigned DW      = 16,
   parameter int unsigned ALU_LAT = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_x,
   input  logic [DW-1:0] wr_y,
   input  logic          start,
   input  logic [AW:0]   count,
   output logic [DW-1:0] Mem_Data_X,
   output logic [DW-1:0] Mem_Data_Y,
   output logic          op_valid,
   input  logic [DW-1:0] Z,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          busy,
   output logic          done
);

   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned CW    = AW + 1;
   localparam int unsigned LW    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      STORE  = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t          state, state_n;
   logic [AW-1:0]   idx, idx_n;
   logic [AW-1:0]   last, last_n;
   logic [LW-1:0]   wcnt, wcnt_n;
   logic [DW-1:0]   x_n, y_n;
   logic            opv_n, busy_n, done_n;
   logic [CW-1:0]   cnt_clamp;

   logic [DW-1:0]   mem_x   [DEPTH];
   logic [DW-1:0]   mem_y   [DEPTH];
   logic [DW-1:0]   res_mem [DEPTH];

   // Operand buffer: written from the host port at any time, never cleared.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_x[wr_addr] <= wr_x;
         mem_y[wr_addr] <= wr_y;
      end
   end

   // Result buffer: captures Z on the single STORE cycle of each pair.
   always_ff @(posedge CLK) begin
      if (state == STORE) begin
         res_mem[idx] <= Z;
      end
   end

   // Registered readback, independent of the sequencer state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_data <= '0;
      end else begin
         rd_data <= res_mem[rd_addr];
      end
   end

   // Requests longer than the buffer are clamped to the whole buffer.
   always_comb begin
      cnt_clamp = count;
      if (count > CW'(DEPTH)) begin
         cnt_clamp = CW'(DEPTH);
      end
   end

   // State and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         idx        <= '0;
         last       <= '0;
         wcnt       <= '0;
         Mem_Data_X <= '0;
         Mem_Data_Y <= '0;
         op_valid   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         last       <= last_n;
         wcnt       <= wcnt_n;
         Mem_Data_X <= x_n;
         Mem_Data_Y <= y_n;
         op_valid   <= opv_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

   // Next-state and next-output logic; done is a one-cycle pulse set on entry to FINISH.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      last_n  = last;
      wcnt_n  = wcnt;
      x_n     = Mem_Data_X;
      y_n     = Mem_Data_Y;
      opv_n   = op_valid;
      busy_n  = busy;
      done_n  = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               if (count != '0) begin
                  state_n = ISSUE;
                  idx_n   = '0;
                  last_n  = AW'(cnt_clamp - CW'(1));
                  busy_n  = 1'b1;
               end else begin
                  state_n = FINISH;
                  done_n  = 1'b1;
               end
            end
         end
         ISSUE: begin
            x_n     = mem_x[idx];
            y_n     = mem_y[idx];
            opv_n   = 1'b1;
            wcnt_n  = LW'(ALU_LAT - 1);
            state_n = WAIT;
         end
         WAIT: begin
            if (wcnt == '0) begin
               state_n = STORE;
            end else begin
               wcnt_n = wcnt - LW'(1);
            end
         end
         STORE: begin
            opv_n = 1'b0;
            if (idx == last) begin
               state_n = FINISH;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else begin
               idx_n   = idx + AW'(1);
               state_n = ISSUE;
            end
         end
         FINISH: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            opv_n   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_operand_responder.sv
// Bench for alu_operand_responder: three instances (ALU_LAT = 2, 1, 4) share the host inputs,
// each paired with a pipelined adder ALU that emits garbage when its input was not a live pair.
module tb_alu_operand_responder;

   localparam int NI = 3;

   logic        CLK = 1'b0;
   logic        RST;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_x, wr_y;
   logic        start;
   logic [3:0]  count;
   logic [2:0]  rd_addr;

   logic [15:0] mx_a [NI];
   logic [15:0] my_a [NI];
   logic [15:0] rdd_a [NI];
   logic [15:0] z_a [NI];
   logic        opv_a [NI];
   logic        busy_a [NI];
   logic        done_a [NI];

   typedef struct {
      int          inst;
      int          addr;
      logic [15:0] val;
   } exp_t;

   exp_t        sbq [$];
   logic [15:0] opx [8];
   logic [15:0] opy [8];
   logic [15:0] res_m [NI][8];
   int          n_tot = 0;
   int          n_bad = 0;

   always #5 CLK = ~CLK;

   function automatic int lat(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      logic [15:0] pipe [L];

      // Adder ALU with L-cycle latency; non-live inputs produce random results.
      always @(posedge CLK) begin
         pipe[0] <= opv_a[g] ? 16'(mx_a[g] + my_a[g]) : 16'($urandom);
         for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
      end
      assign z_a[g] = pipe[L-1];

      alu_operand_responder #(.AW(3), .DW(16), .ALU_LAT(L)) dut (
         .CLK        (CLK),
         .RST        (RST),
         .wr_en      (wr_en),
         .wr_addr    (wr_addr),
         .wr_x       (wr_x),
         .wr_y       (wr_y),
         .start      (start),
         .count      (count),
         .Mem_Data_X (mx_a[g]),
         .Mem_Data_Y (my_a[g]),
         .op_valid   (opv_a[g]),
         .Z          (z_a[g]),
         .rd_addr    (rd_addr),
         .rd_data    (rdd_a[g]),
         .busy       (busy_a[g]),
         .done       (done_a[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_zero(input string tag);
      for (int g = 0; g < NI; g++) begin
         check($sformatf("%s_opv%0d", tag, g), 32'(opv_a[g]), 32'd0);
         check($sformatf("%s_busy%0d", tag, g), 32'(busy_a[g]), 32'd0);
         check($sformatf("%s_done%0d", tag, g), 32'(done_a[g]), 32'd0);
         check($sformatf("%s_mx%0d", tag, g), 32'(mx_a[g]), 32'd0);
         check($sformatf("%s_my%0d", tag, g), 32'(my_a[g]), 32'd0);
         check($sformatf("%s_rd%0d", tag, g), 32'(rdd_a[g]), 32'd0);
      end
   endtask

   task automatic load(input int a, input logic [15:0] x, input logic [15:0] y);
      wr_en = 1'b1; wr_addr = 3'(a); wr_x = x; wr_y = y;
      tick();
      wr_en = 1'b0;
      opx[a] = x; opy[a] = y;
   endtask

   // Runs one start..done sequence; optional second start (s2), write (wc) and reset (rc) cycles.
   task automatic run(input string tag, input int cnt_in, input int s2, input int wc, input int wa,
                      input logic [15:0] wx, input logic [15:0] wy, input int rc);
      int eff, budget, L;
      int first [NI];
      int pulses [NI];
      int opvc [NI];
      int ns [NI];
      int expd [NI];
      logic [15:0] v;
      eff = (cnt_in > 8) ? 8 : cnt_in;
      budget = ((eff == 0) ? 1 : eff * 6 + 1) + 4;
      for (int g = 0; g < NI; g++) begin
         L = lat(g);
         first[g] = 0; pulses[g] = 0; opvc[g] = 0;
         expd[g] = (rc > 0) ? 0 : ((eff == 0) ? 1 : eff * (L + 2) + 1);
         ns[g] = eff;
         if (rc > 0) begin
            ns[g] = 0;
            for (int k = 0; k < eff; k++) if ((k + 1) * (L + 2) < rc) ns[g]++;
         end
         for (int k = 0; k < ns[g]; k++) begin
            if (wc > 0 && k == wa && wc < 1 + wa * (L + 2)) v = 16'(wx + wy);
            else v = 16'(opx[k] + opy[k]);
            sbq.push_back('{g, k, v});
            res_m[g][k] = v;
         end
      end
      start = 1'b1; count = 4'(cnt_in);
      for (int t = 1; t <= budget; t++) begin
         tick();
         for (int g = 0; g < NI; g++) begin
            if (done_a[g]) begin
               pulses[g]++;
               if (first[g] == 0) first[g] = t;
            end
            if (opv_a[g]) opvc[g]++;
         end
         start = (t == s2);
         wr_en = (t == wc); wr_addr = 3'(wa); wr_x = wx; wr_y = wy;
         if (t == rc) begin
            RST = 1'b1;
            #1;
            check_zero({tag, "_rst"});
         end
         if (rc > 0 && t == rc + 1) RST = 1'b0;
      end
      start = 1'b0; wr_en = 1'b0;
      if (wc > 0) begin opx[wa] = wx; opy[wa] = wy; end
      for (int g = 0; g < NI; g++) begin
         check($sformatf("%s_done_cyc%0d", tag, g), 32'(first[g]), 32'(expd[g]));
         check($sformatf("%s_done_cnt%0d", tag, g), 32'(pulses[g]), (rc > 0) ? 32'd0 : 32'd1);
         check($sformatf("%s_busy_end%0d", tag, g), 32'(busy_a[g]), 32'd0);
         if (rc == 0)
            check($sformatf("%s_opv_cyc%0d", tag, g), 32'(opvc[g]), 32'(eff * (lat(g) + 1)));
      end
   endtask

   task automatic readback(input string tag);
      exp_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         rd_addr = 3'(e.addr);
         tick();
         check($sformatf("%s_rd%0d_a%0d", tag, e.inst, e.addr), 32'(rdd_a[e.inst]), 32'(e.val));
      end
   endtask

   initial begin
      RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0;
      start = 1'b0; count = '0; rd_addr = '0;
      tick(); tick();
      check_zero("reset");
      RST = 1'b0;
      tick();

      // Single pair: 23 + (-8).
      load(0, 16'd23, 16'hFFF8);
      run("t1", 1, 0, 0, 0, 16'h0, 16'h0, 0);
      for (int g = 0; g < NI; g++) begin
         check($sformatf("t1_mx%0d", g), 32'(mx_a[g]), 32'h0017);
         check($sformatf("t1_my%0d", g), 32'(my_a[g]), 32'hFFF8);
      end
      readback("t1");

      // Full buffer of (i, 2i).
      for (int i = 0; i < 8; i++) load(i, 16'(i), 16'(2 * i));
      run("t2", 8, 0, 0, 0, 16'h0, 16'h0, 0);
      readback("t2");

      // Zero-length run leaves results untouched.
      run("t3", 0, 0, 0, 0, 16'h0, 16'h0, 0);
      for (int g = 0; g < NI; g++)
         for (int k = 0; k < 8; k++) sbq.push_back('{g, k, res_m[g][k]});
      readback("t3");

      // Restart attempt plus write to an already-issued index.
      for (int i = 0; i < 8; i++) load(i, 16'(16'h0300 + i), 16'(16'h1000 * i));
      run("t4", 8, 5, 10, 0, 16'h1111, 16'h2222, 0);
      readback("t4");

      // Write to a not-yet-issued index is picked up by the run.
      run("t5", 8, 0, 3, 7, 16'h0100, 16'h0200, 0);
      readback("t5");

      // Oversized count clamps to the buffer depth.
      for (int i = 0; i < 8; i++) load(i, 16'(7 * i + 1), 16'(16'hF000 + i));
      run("t6", 12, 0, 0, 0, 16'h0, 16'h0, 0);
      readback("t6");

      // Abort during the wait of pair 3 (ALU_LAT=2 instance); earlier results survive.
      for (int i = 0; i < 8; i++) load(i, 16'(16'h0A00 + 5 * i), 16'(100 + i));
      run("t7", 8, 0, 0, 0, 16'h0, 16'h0, 14);
      readback("t7");

      // Recovery after abort.
      run("t8", 2, 0, 0, 0, 16'h0, 16'h0, 0);
      readback("t8");

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
